// File: rtl/qspi_flash_reader_if.sv
// Request/response bus between system fetch logic and qspi_flash_reader.
interface qspi_flash_reader_if #(
  parameter int LEN_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             done;
  logic             busy;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready, rd_data, rd_valid, done, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready, rd_data, rd_valid, done, busy
  );
endinterface

// File: rtl/qspi_flash_reader.sv
// SPI mode-0 read controller for serial flash: READ + 24-bit address, byte stream out.
// Define QSPI_QUAD_READ_EN for Fast Read Quad Output (0x6B, 8 dummy clocks, 4-bit data).
module qspi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  qspi_flash_reader_if.slave       bus,
  output logic                     cs_n,
  output logic                     sck,
  output logic [3:0]               io_out,
  output logic [3:0]               io_oe,
  input  logic [3:0]               io_in
);
`ifdef QSPI_QUAD_READ_EN
  localparam logic [7:0] OPCODE = 8'h6B;
  localparam logic       QUAD   = 1'b1;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  localparam logic       QUAD   = 1'b0;
`endif
  localparam int         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [4:0] BIT_LAST = QUAD ? 5'd1 : 5'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_ZLEN, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_CS_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic [3:0]       io_out_q, io_out_d;
  logic [3:0]       io_oe_q, io_oe_d;
  logic             tick;
  logic [7:0]       rx_next;

  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign rx_next = QUAD ? {rx_q[3:0], io_in} : {rx_q[6:0], io_in[1]};

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    cnt_d       = cnt_q;
    len_d       = len_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    req_ready_d = req_ready_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (bus.req_valid && req_ready_q) begin
          len_d       = bus.req_len;
          tx_d        = {OPCODE, bus.req_addr};
          req_ready_d = 1'b0;
          if (bus.req_len == '0) begin
            state_d = S_ZLEN;
            done_d  = 1'b1;
          end else begin
            state_d  = S_CS_SETUP;
            cs_n_d   = 1'b0;
            io_oe_d  = 4'b1101;
            io_out_d = {3'b110, OPCODE[7]};
          end
        end
      end
      S_ZLEN: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      S_CS_SETUP: if (tick) begin
        sck_d   = 1'b1;
        state_d = S_CMD;
        cnt_d   = '0;
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: if (tick) begin
        sck_d = ~sck_q;
        if (!sck_q) begin
          // Rising edge: sample read data; the last bit of a byte completes it.
          if (state_q == S_DATA) begin
            rx_d = rx_next[6:0];
            if (cnt_q == BIT_LAST) begin
              rd_valid_d = 1'b1;
              rd_data_d  = rx_next;
              len_d      = len_q - LEN_W'(1);
            end
          end
        end else begin
          // Falling edge: advance MOSI and move between phases.
          cnt_d = cnt_q + 5'd1;
          case (state_q)
            S_CMD: begin
              tx_d        = {tx_q[30:0], tx_q[31]};
              io_out_d[0] = tx_q[30];
              if (cnt_q == 5'd7) begin
                state_d = S_ADDR;
                cnt_d   = '0;
              end
            end
            S_ADDR: begin
              tx_d        = {tx_q[30:0], tx_q[31]};
              io_out_d[0] = tx_q[30];
              if (cnt_q == 5'd23) begin
                cnt_d    = '0;
                io_out_d = 4'b1100;
                state_d  = QUAD ? S_DUMMY : S_DATA;
                io_oe_d  = QUAD ? 4'b0000 : 4'b1100;
              end
            end
            S_DUMMY: if (cnt_q == 5'd7) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end
            default: if (cnt_q == BIT_LAST) begin
              cnt_d = '0;
              if (len_q == '0) state_d = S_CS_HOLD;
            end
          endcase
        end
      end
      S_CS_HOLD: if (tick) begin
        state_d  = S_CS_IDLE;
        cs_n_d   = 1'b1;
        done_d   = 1'b1;
        io_oe_d  = 4'b0000;
        io_out_d = 4'b1100;
      end
      S_CS_IDLE: if (tick) begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = ~req_ready_d;
  end

  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      io_out_q    <= 4'b1100;
      io_oe_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign cs_n          = cs_n_q;
  assign sck           = sck_q;
  assign io_out        = io_out_q;
  assign io_oe         = io_oe_q;
endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: behavioural flash model, expected-byte queue, rd_valid monitor.
module tb_qspi_flash_reader;
  localparam int CLK_DIV = 2;
`ifdef QSPI_QUAD_READ_EN
  localparam logic [7:0] OPC        = 8'h6B;
  localparam int         DATA_START = 40;
  localparam logic [3:0] DATA_OE    = 4'b0000;
`else
  localparam logic [7:0] OPC        = 8'h03;
  localparam int         DATA_START = 32;
  localparam logic [3:0] DATA_OE    = 4'b1100;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n, sck;
  logic [3:0] io_out, io_oe, io_in;
  logic [3:0] dev_io = 4'b0000;

  qspi_flash_reader_if #(.LEN_W(16)) bus ();

  qspi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cs_n(cs_n), .sck(sck), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 clk = ~clk;
  assign io_in = (io_oe & io_out) | (~io_oe & dev_io);

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int cs_low = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [int];

  // Flash model state
  int          rise_cnt = 0;
  logic [31:0] mosi_sr  = '0;
  bit          oe_bad   = 1'b0;

  function automatic logic [7:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_rises(input int len);
`ifdef QSPI_QUAD_READ_EN
    return 40 + 2 * len;
`else
    return 32 + 8 * len;
`endif
  endfunction

  always @(negedge cs_n) begin
    rise_cnt = 0;
    mosi_sr  = '0;
    oe_bad   = 1'b0;
    dev_io   = 4'b0000;
  end

  always @(posedge sck) if (cs_n === 1'b0) begin
    rise_cnt++;
    if (rise_cnt <= 32) begin
      mosi_sr = {mosi_sr[30:0], io_out[0]};
      if (io_oe !== 4'b1101) oe_bad = 1'b1;
    end else if (rise_cnt <= DATA_START) begin
      if (io_oe !== 4'b0000) oe_bad = 1'b1;
    end else if (io_oe !== DATA_OE) oe_bad = 1'b1;
  end

  always @(negedge sck) if (cs_n === 1'b0 && rise_cnt >= DATA_START) begin
    int k;
    logic [7:0] b;
    k = rise_cnt - DATA_START;
`ifdef QSPI_QUAD_READ_EN
    b = mem_rd(int'(mosi_sr[23:0]) + k / 2);
    dev_io = (k % 2 == 0) ? b[7:4] : b[3:0];
`else
    b = mem_rd(int'(mosi_sr[23:0]) + k / 8);
    dev_io = {2'b00, b[7 - (k % 8)], 1'b0};
`endif
  end

  // Monitor: every rd_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (cs_n === 1'b0) cs_low++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0h expected none", bus.rd_data);
      end else begin
        check("rd_data", {24'h0, bus.rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [23:0] a, input logic [15:0] l);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("ready_timeout", 32'd1, 32'd0);
    cs_low = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("done_timeout", 32'd1, 32'd0);
    repeat (CLK_DIV + 2) @(negedge clk);
  endtask

  initial begin
    int d0, n;
    bit moved;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[32'hA5C3F0] = 8'h7E;
    mem[32'h10] = 8'hA1; mem[32'h11] = 8'hB2;
    mem[32'h200] = 8'h5A; mem[32'h201] = 8'hC3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", {31'h0, cs_n}, 32'd1);
    check("rst_sck", {31'h0, sck}, 32'd0);
    check("rst_io_oe", {28'h0, io_oe}, 32'h0);
    check("rst_io_out", {28'h0, io_out}, 32'hC);
    check("rst_ready", {31'h0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'h0, bus.busy}, 32'd0);
    check("rst_rd_valid", {31'h0, bus.rd_valid}, 32'd0);
    check("rst_done", {31'h0, bus.done}, 32'd0);
    check("rst_rd_data", {24'h0, bus.rd_data}, 32'h0);
    rst = 1'b0;

    moved = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sck !== 1'b0 || io_oe !== 4'b0000 || bus.req_ready !== 1'b1 ||
          bus.done !== 1'b0 || bus.rd_valid !== 1'b0) moved = 1'b1;
    end
    check("idle_stable", {31'h0, moved}, 32'd0);

    // Four bytes from address 0
    d0 = done_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    issue(24'h000000, 16'd4);
    @(negedge clk);
    check("busy_during", {31'h0, bus.busy}, 32'd1);
    wait_done(d0);
    check("t4_mosi", mosi_sr, {OPC, 24'h000000});
    check("t4_rises", rise_cnt, n_rises(4));
    check("t4_cs_low", cs_low, CLK_DIV * (2 * n_rises(4) + 1));
    check("t4_done_once", done_cnt - d0, 32'd1);
    check("t4_oe", {31'h0, oe_bad}, 32'd0);
    check("t4_drained", exp_q.size(), 32'd0);
    check("t4_ready_back", {31'h0, bus.req_ready}, 32'd1);

    // Address bit pattern, one byte
    d0 = done_cnt;
    exp_q.push_back(8'h7E);
    issue(24'hA5C3F0, 16'd1);
    wait_done(d0);
    check("t1_mosi", mosi_sr, {OPC, 24'hA5C3F0});
    check("t1_rises", rise_cnt, n_rises(1));
    check("t1_drained", exp_q.size(), 32'd0);

    // Zero length
    d0 = done_cnt;
    @(negedge clk);
    cs_low = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 24'h123456;
    bus.req_len   = 16'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("zl_done1", {31'h0, bus.done}, 32'd1);
    check("zl_ready1", {31'h0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("zl_done2", {31'h0, bus.done}, 32'd0);
    check("zl_ready2", {31'h0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("zl_cs", cs_low, 32'd0);
    check("zl_done_once", done_cnt - d0, 32'd1);

    // Reset in the address phase, then a fresh request
    d0 = done_cnt;
    issue(24'h000100, 16'd4);
    n = 0;
    while (rise_cnt < 16 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ab_reach_addr", {31'h0, n >= 2000}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ab_cs_n", {31'h0, cs_n}, 32'd1);
    check("ab_sck", {31'h0, sck}, 32'd0);
    check("ab_ready", {31'h0, bus.req_ready}, 32'd1);
    check("ab_io_oe", {28'h0, io_oe}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("ab_no_done", done_cnt - d0, 32'd0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    issue(24'h000010, 16'd2);
    wait_done(d0);
    check("ab_mosi", mosi_sr, {OPC, 24'h000010});
    check("ab_drained", exp_q.size(), 32'd0);

    // Two bytes, checks pad enables in each phase
    d0 = done_cnt;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    issue(24'h000200, 16'd2);
    wait_done(d0);
    check("t2_mosi", mosi_sr, {OPC, 24'h000200});
    check("t2_rises", rise_cnt, n_rises(2));
    check("t2_oe", {31'h0, oe_bad}, 32'd0);
    check("t2_drained", exp_q.size(), 32'd0);
    check("end_cs_n", {31'h0, cs_n}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qspi_flash_reader.md
Name: qspi_flash_reader

Overview:
- Host-side read controller that drives the serial flash pins (cs_n, sck, io[3:0]) of qspi_flash_device.
- Accepts a read request (24-bit address, byte count) on a valid/ready handshake.
- Issues READ (0x03) plus the address serially, then returns the received bytes as a one-cycle-pulse stream.
- Sits between the system-side fetch logic and the flash pads. The top level builds the tristate as io = io_oe[i] ? io_out[i] : 1'bz.

Parameters:
- CLK_DIV, 2, sck half-period in clk cycles (>=1); sck period = 2*CLK_DIV clk.
- LEN_W, 16, width of the byte-count field.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  read request valid
- req_ready  output  1  controller idle, can accept
- req_addr  input  24  flash start byte address
- req_len  input  LEN_W  number of bytes to read
- rd_data  output  8  received byte
- rd_valid  output  1  one-cycle pulse, rd_data valid
- done  output  1  one-cycle pulse, transaction finished
- busy  output  1  transaction in progress
- cs_n  output  1  flash chip select, active-low
- sck  output  1  flash serial clock
- io_out  output  4  pad output values
- io_oe  output  4  pad output enables
- io_in  input  4  pad input values

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: cs_n=1, sck=0, io_out=4'b1100, io_oe=4'b0000, req_ready=1, busy=0, rd_valid=0, done=0, rd_data=0.
- Reset mid-transaction: the next cycle returns to reset values. No rd_valid or done is emitted for the aborted transfer.
- SPI mode 0:
  - sck idles low.
  - The host updates io_out on the clk edge where sck falls (the first bit is presented at the cs_n fall).
  - The host samples io_in on the clk edge where sck rises.
- Single-bit pin map: io[0]=MOSI, io[1]=MISO. During CMD/ADDR: io_oe=4'b1101, io_out[3:2]=2'b11 (WP#/HOLD# high). During DATA: io_oe=4'b1100.
- Handshake: a request is accepted on a clk edge with req_valid && req_ready. req_addr and req_len are latched. req_ready drops the next cycle.
- req_len==0: accepted, cs_n never asserts, done pulses the cycle after acceptance, req_ready returns the cycle after that.
- States: IDLE -> CS_SETUP -> CMD -> ADDR -> [DUMMY] -> DATA -> CS_HOLD -> CS_IDLE -> IDLE.
  - IDLE: waits for a request.
  - CS_SETUP: cs_n=0 starting the cycle after acceptance. The first sck rise occurs CLK_DIV clks later.
  - CMD: 8 sck, opcode MSB first.
  - ADDR: 24 sck, address MSB first.
  - DATA: 8 sck per byte, MSB first. The shift register samples io_in[1]. rd_valid pulses the cycle after the 8th sampling rise of each byte.
  - CS_HOLD: after the final sck fall, sck stays 0. cs_n rises CLK_DIV clks later; done pulses in that same cycle.
  - CS_IDLE: cs_n held high for CLK_DIV clks, then IDLE with req_ready=1.
- Edge count and timing: sck has exactly N rising edges per transaction, N = 32 + 8*req_len. cs_n is low for CLK_DIV*(2N+1) clks.
- busy = !req_ready except during the reset cycle.
- Byte counter: LEN_W bits, decrements per byte. No wrap; the maximum length 2^LEN_W-1 is supported.
- Address: no address wrap is generated by the controller (the flash wraps internally).
- rd_valid has no backpressure. Consumers must accept every pulse.

Optional Feature:
- QSPI_QUAD_READ_EN defined:
  - Opcode is 0x6B (Fast Read Quad Output). CMD and ADDR stay single-bit on io[0].
  - DUMMY state: 8 sck with io_oe=4'b0000.
  - DATA: io_oe=4'b0000. Sample io_in[3:0] per rise, high nibble first, 2 sck per byte.
  - N = 40 + 2*req_len.
- Undefined: opcode 0x03, no DUMMY state, single-bit data as above.

Test Plan:
- Reset then idle: cs_n=1, sck=0, io_oe=0, req_ready=1. Hold 10 clks and check nothing toggles.
- CLK_DIV=2, addr 0x000000, len 4, device memory bytes 0x11,0x22,0x33,0x44:
  - io[0] shifts 0x03 then 24 zeros.
  - rd_valid fires 4 times with 0x11,0x22,0x33,0x44.
  - cs_n low for exactly 258 clks; done pulses once.
- addr 0xA5C3F0, len 1: captured MOSI bit stream equals 0x03A5C3F0 MSB first. Exactly 40 sck rises.
- len=0: no cs_n assertion; done the cycle after accept; req_ready high 2 cycles after accept.
- Assert rst mid-ADDR, then issue a new request (addr 0x000010, len 2): cs_n=1 the cycle after rst, no stray rd_valid/done. The new transaction returns the correct 2 bytes.
- With QSPI_QUAD_READ_EN, len 2, data 0x5A,0xC3: opcode 0x6B, 8 dummy sck with io_oe=0. rd_valid yields 0x5A then 0xC3. 44 sck rises in total.
